// File: rtl/driver_vector_fetch_if.sv
// ----------------------------------------------------------------------------
// driver_vector_fetch_if
//   Read bus between the vector fetcher and the memory master.
//   Carries:
//     master_addr        read address (fetcher -> memory)
//     master_rd          one-cycle read strobe (fetcher -> memory)
//     master_data_in     returned read data (memory -> fetcher)
//     master_data_in_val returned data valid (memory -> fetcher)
//   Modports: master = fetcher side, slave = memory side.
// ----------------------------------------------------------------------------
interface driver_vector_fetch_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0] master_addr;
   logic              master_rd;
   logic [DATA_W-1:0] master_data_in;
   logic              master_data_in_val;

   modport master (
      output master_addr,
      output master_rd,
      input  master_data_in,
      input  master_data_in_val
   );

   modport slave (
      input  master_addr,
      input  master_rd,
      output master_data_in,
      output master_data_in_val
   );
endinterface

// File: rtl/driver_vector_fetch.sv
// ----------------------------------------------------------------------------
// driver_vector_fetch
//   Fetches a WORDS-word test vector from memory.  A get_vector request latches
//   a base address, then WORDS single-beat reads are issued at base,
//   base+STRIDE, ... (addresses wrap modulo 2^ADDR_W).  Only one read is ever
//   outstanding.  Each returned beat is written into its slot of vector_data
//   and a one-cycle vector_valid pulse follows the last beat.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     test_vector_addr  base address, sampled when a request is accepted
//     get_vector        request, accepted only when idle
//     busy              high while reads are being issued / awaited
//     bus               read bus (driver_vector_fetch_if.master)
//     vector_data       collected vector, word i at [i*DATA_W +: DATA_W]
//     vector_valid      one-cycle pulse once all words are captured
//     vector_error      one-cycle pulse on a beat timeout (optional feature)
//
//   Optional feature: define DRIVER_VECTOR_FETCH_TIMEOUT_EN to abort a fetch
//   when a beat has not arrived within TIMEOUT cycles.  Without it the fetcher
//   waits indefinitely and vector_error is constant 0.
// ----------------------------------------------------------------------------
module driver_vector_fetch #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int WORDS   = 3,
   parameter int STRIDE  = 8,
   parameter int TIMEOUT = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       test_vector_addr,
   input  logic                    get_vector,
   output logic                    busy,
   driver_vector_fetch_if.master   bus,
   output logic [WORDS*DATA_W-1:0] vector_data,
   output logic                    vector_valid,
   output logic                    vector_error
);

   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

   if (WORDS < 1 || WORDS > 16 || TIMEOUT < 1) begin : g_param_check
      $error("driver_vector_fetch: WORDS must be 1..16 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  idx;
   // Address of the word currently being fetched; starts at the latched base.
   logic [ADDR_W-1:0] base;

`ifdef DRIVER_VECTOR_FETCH_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   logic [WAIT_W-1:0] wait_cnt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         idx             <= '0;
         base            <= '0;
         busy            <= 1'b0;
         bus.master_addr <= '0;
         bus.master_rd   <= 1'b0;
         vector_data     <= '0;
         vector_valid    <= 1'b0;
         vector_error    <= 1'b0;
`ifdef DRIVER_VECTOR_FETCH_TIMEOUT_EN
         wait_cnt        <= '0;
`endif
      end else begin
         // Strobes and pulses are single-cycle unless re-asserted below.
         bus.master_rd <= 1'b0;
         vector_valid  <= 1'b0;
         vector_error  <= 1'b0;

         case (state)
            S_IDLE: begin
               // Strobe is registered here so the read appears one cycle
               // after the request, while the FSM sits in ISSUE.
               if (get_vector) begin
                  base            <= test_vector_addr;
                  bus.master_addr <= test_vector_addr;
                  bus.master_rd   <= 1'b1;
                  idx             <= '0;
                  busy            <= 1'b1;
                  state           <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               // A beat coinciding with the strobe is not a reply; ignore it.
`ifdef DRIVER_VECTOR_FETCH_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (bus.master_data_in_val) begin
                  vector_data[idx*DATA_W +: DATA_W] <= bus.master_data_in;
                  if (idx == LAST_IDX) begin
                     busy         <= 1'b0;
                     vector_valid <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     idx             <= idx + 1'b1;
                     base            <= base + STEP;
                     bus.master_addr <= base + STEP;
                     bus.master_rd   <= 1'b1;
                     state           <= S_ISSUE;
                  end
               end
`ifdef DRIVER_VECTOR_FETCH_TIMEOUT_EN
               // A beat in the final allowed cycle is taken above, so the
               // error only fires when the window closes with no beat.
               else if (wait_cnt == WAIT_LAST) begin
                  busy         <= 1'b0;
                  vector_error <= 1'b1;
                  state        <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_driver_vector_fetch.sv
`timescale 1ns/1ps
module tb_driver_vector_fetch;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int WORDS   = 3;
   localparam int STRIDE  = 8;
   localparam int TIMEOUT = 16;
   localparam int VW      = WORDS * DATA_W;
   localparam int AW      = WORDS * ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] test_vector_addr;
   logic              get_vector;
   logic              busy;
   logic [VW-1:0]     vector_data;
   logic              vector_valid;
   logic              vector_error;

   driver_vector_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   driver_vector_fetch #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS),
      .STRIDE(STRIDE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .test_vector_addr (test_vector_addr),
      .get_vector       (get_vector),
      .busy             (busy),
      .bus              (bus),
      .vector_data      (vector_data),
      .vector_valid     (vector_valid),
      .vector_error     (vector_error)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference contents of the vector register: what each slot should hold.
   logic [DATA_W-1:0] model_words [WORDS];

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [VW-1:0]     words;
      logic [AW-1:0]     addrs;
      logic [VW-1:0]     vec;
      int                lat;
   } vec_t;

   vec_t tbl [3];

   task automatic check(input string name, input logic [VW-1:0] act,
                        input logic [VW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < WORDS; k++) v[k*DATA_W +: DATA_W] = model_words[k];
      return v;
   endfunction

   function automatic logic [AW-1:0] addr_list(input logic [ADDR_W-1:0] b);
      logic [AW-1:0] a;
      for (int k = 0; k < WORDS; k++)
         a[k*ADDR_W +: ADDR_W] = b + ADDR_W'(k * STRIDE);
      return a;
   endfunction

   // One complete fetch starting from IDLE. Ends in the IDLE cycle after
   // vector_valid; with hold=1 get_vector stays high so the next call's
   // request is the one accepted in that IDLE cycle.
   task automatic run_fetch(input logic [ADDR_W-1:0] base,
                            input logic [AW-1:0] exp_addr,
                            input logic [VW-1:0] words, input int lat,
                            input bit stray, input bit hold);
      get_vector       = 1'b1;
      test_vector_addr = base;
      tick();
      if (!hold) get_vector = 1'b0;
      test_vector_addr = ~base;
      for (int k = 0; k < WORDS; k++) begin
         check("issue_rd",   bus.master_rd, 1);
         check("issue_addr", bus.master_addr, exp_addr[k*ADDR_W +: ADDR_W]);
         check("issue_busy", busy, 1);
         if (stray && k == 0) begin
            bus.master_data_in_val = 1'b1;
            bus.master_data_in     = 64'hDEAD_BEEF_0BAD_F00D;
         end
         tick();
         bus.master_data_in_val = 1'b0;
         bus.master_data_in     = {$urandom, $urandom};
         for (int w = 0; w < lat; w++) begin
            check("wait_quiet", {bus.master_rd, vector_valid, busy}, 3'b001);
            if (w == lat - 1) begin
               bus.master_data_in_val = 1'b1;
               bus.master_data_in     = words[k*DATA_W +: DATA_W];
            end
            tick();
         end
         bus.master_data_in_val = 1'b0;
         model_words[k] = words[k*DATA_W +: DATA_W];
      end
      check("done_flags", {vector_valid, vector_error, busy, bus.master_rd}, 4'b1000);
      check("done_data", vector_data, model_vec());
      tick();
      check("idle_after", {vector_valid, busy, bus.master_rd}, 3'b000);
      if (!hold) get_vector = 1'b0;
   endtask

   initial begin
      reset                  = 1'b1;
      get_vector             = 1'b0;
      test_vector_addr       = '0;
      bus.master_data_in     = '0;
      bus.master_data_in_val = 1'b0;
      for (int k = 0; k < WORDS; k++) model_words[k] = '0;

      tbl[0] = '{base: 64'h1000,
                 words: {64'hA2, 64'hA1, 64'hA0},
                 addrs: {64'h1010, 64'h1008, 64'h1000},
                 vec:   {64'hA2, 64'hA1, 64'hA0}, lat: 2};
      tbl[1] = '{base: 64'hFFFF_FFFF_FFFF_FFF8,
                 words: {64'hC2, 64'hC1, 64'hC0},
                 addrs: {64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8},
                 vec:   {64'hC2, 64'hC1, 64'hC0}, lat: 1};
      tbl[2] = '{base: 64'h7FFF_FFFF_FFFF_FFF0,
                 words: {64'h3333_0000_0000_0003, 64'h2222, 64'h1111},
                 addrs: {64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFF8,
                         64'h7FFF_FFFF_FFFF_FFF0},
                 vec:   {64'h3333_0000_0000_0003, 64'h2222, 64'h1111}, lat: 3};

      repeat (3) tick();
      reset = 1'b0;

      // Idle after reset: nothing moves even with a stray beat present.
      for (int c = 0; c < 10; c++) begin
         check("reset_idle", {busy, bus.master_rd, vector_valid, vector_error,
                              bus.master_addr}, '0);
         check("reset_data", vector_data, '0);
         bus.master_data_in_val = (c == 4);
         bus.master_data_in     = 64'h5555;
         tick();
      end
      bus.master_data_in_val = 1'b0;

      // Table-driven fetches.
      for (int t = 0; t < 3; t++) begin
         run_fetch(tbl[t].base, tbl[t].addrs, tbl[t].words, tbl[t].lat, 1'b0, 1'b0);
         check("tbl_vec", vector_data, tbl[t].vec);
         tick();
      end

      // get_vector held through a fetch plus a beat during ISSUE; the next
      // fetch must start right after the vector_valid pulse.
      run_fetch(64'h3000, addr_list(64'h3000), {64'hB2, 64'hB1, 64'hB0}, 2, 1'b1, 1'b1);
      run_fetch(64'h4000, addr_list(64'h4000), {64'hD2, 64'hD1, 64'hD0}, 1, 1'b0, 1'b0);

      // Reset while waiting for word 1, then a late beat.
      get_vector       = 1'b1;
      test_vector_addr = 64'h5000;
      tick();
      get_vector = 1'b0;
      tick();
      bus.master_data_in_val = 1'b1;
      bus.master_data_in     = 64'hE0;
      tick();
      bus.master_data_in_val = 1'b0;
      check("rst_seq_issue1", bus.master_addr, 64'h5008);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < WORDS; k++) model_words[k] = '0;
      check("rst_mid_flags", {busy, bus.master_rd, vector_valid, vector_error,
                              bus.master_addr}, '0);
      check("rst_mid_data", vector_data, '0);
      bus.master_data_in_val = 1'b1;
      bus.master_data_in     = 64'hE1;
      tick();
      bus.master_data_in_val = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("late_beat", {busy, bus.master_rd, vector_valid, vector_error}, 4'b0000);
         check("late_data", vector_data, '0);
         tick();
      end
      run_fetch(64'h2000, {64'h2010, 64'h2008, 64'h2000},
                {64'hF2, 64'hF1, 64'hF0}, 2, 1'b0, 1'b0);

      // Randomized fetches against the reference model.
      for (int r = 0; r < 20; r++) begin
         logic [ADDR_W-1:0] b;
         logic [VW-1:0]     w;
         b = {$urandom, $urandom};
         for (int k = 0; k < WORDS; k++) w[k*DATA_W +: DATA_W] = {$urandom, $urandom};
         run_fetch(b, addr_list(b), w, int'($urandom_range(1, 4)),
                   1'($urandom_range(0, 1)),
                   (r == 19) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      get_vector = 1'b0;
      tick();

      // Memory never answers word 0.
      get_vector       = 1'b1;
      test_vector_addr = 64'h6000;
      tick();
      get_vector = 1'b0;
      tick();
`ifdef DRIVER_VECTOR_FETCH_TIMEOUT_EN
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         if (k < TIMEOUT)
            check("to_waiting", {vector_error, vector_valid, busy}, 3'b001);
         else
            check("to_error", {vector_error, vector_valid, busy}, 3'b100);
      end
      tick();
      check("to_after", {vector_error, vector_valid, busy, bus.master_rd}, 4'b0000);
`else
      begin
         bit ok;
         ok = 1'b1;
         for (int k = 0; k < 1000; k++) begin
            if (busy !== 1'b1 || vector_error !== 1'b0 || vector_valid !== 1'b0)
               ok = 1'b0;
            tick();
         end
         check("no_timeout_busy", ok, 1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("no_timeout_reset", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
